// File: rtl/imem_arb_pkg.sv
// Shared defaults, FSM state type and pointer-width helper for the instruction memory arbiter.
package imem_arb_pkg;

    localparam int unsigned NUM_CORES_DEF  = 4;
    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned DATA_WIDTH_DEF = 32;

    // Round-robin pointer width for a given core count (at least 1 bit).
    function automatic int unsigned ptr_width(input int unsigned num_cores);
        return (num_cores > 1) ? $clog2(num_cores) : 1;
    endfunction

    localparam int unsigned PTR_WIDTH_DEF = ptr_width(NUM_CORES_DEF);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// Bus between the cores' IF stages, the arbiter and the instruction memory.
// Optional IMEM_ARB_PERF_EN adds the per-core stall counter bus.
interface imem_arbiter_if #(
    parameter int unsigned NUM_CORES  = imem_arb_pkg::NUM_CORES_DEF,
    parameter int unsigned ADDR_WIDTH = imem_arb_pkg::ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = imem_arb_pkg::DATA_WIDTH_DEF
) ();

    logic [NUM_CORES-1:0]            Core_Enable;
    logic [NUM_CORES-1:0]            Req;
    logic [NUM_CORES*ADDR_WIDTH-1:0] PC;
    logic [ADDR_WIDTH-1:0]           Mem_Address;
    logic [DATA_WIDTH-1:0]           Mem_Instruction;
    logic [NUM_CORES-1:0]            Resp_Valid;
    logic [DATA_WIDTH-1:0]           Instruction;
    logic                            Busy;
`ifdef IMEM_ARB_PERF_EN
    logic [NUM_CORES*32-1:0]         Perf_Stall_Count;
`endif

    // Cores and memory side.
    modport master (
        output Core_Enable, Req, PC, Mem_Instruction,
`ifdef IMEM_ARB_PERF_EN
        input  Perf_Stall_Count,
`endif
        input  Mem_Address, Resp_Valid, Instruction, Busy
    );

    // Arbiter side.
    modport slave (
        input  Core_Enable, Req, PC, Mem_Instruction,
`ifdef IMEM_ARB_PERF_EN
        output Perf_Stall_Count,
`endif
        output Mem_Address, Resp_Valid, Instruction, Busy
    );

endinterface

// File: rtl/imem_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set bit of eligible_i at or above ptr_i, wrapping.
module rr_priority_picker #(
    parameter int unsigned NUM_CORES = imem_arb_pkg::NUM_CORES_DEF,
    parameter int unsigned PTR_WIDTH = imem_arb_pkg::ptr_width(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] eligible_i,
    input  logic [PTR_WIDTH-1:0] ptr_i,
    output logic [NUM_CORES-1:0] winner_oh_o,
    output logic [PTR_WIDTH-1:0] winner_idx_o,
    output logic                 any_o
);

    logic [PTR_WIDTH-1:0] cand;

    // Scan NUM_CORES positions starting from the pointer; first hit wins.
    always_comb begin
        winner_oh_o  = '0;
        winner_idx_o = '0;
        any_o        = 1'b0;
        cand         = '0;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            cand = PTR_WIDTH'((int'(ptr_i) + i) % int'(NUM_CORES));
            if (!any_o && eligible_i[cand]) begin
                any_o              = 1'b1;
                winner_idx_o       = cand;
                winner_oh_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin instruction memory arbiter: one grant per cycle, registered address,
// response valid one cycle after the winning edge.
// Optional IMEM_ARB_PERF_EN adds saturating per-core stall counters.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES  = NUM_CORES_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic          Clk,
    input  logic          Rst,
    imem_arbiter_if.slave bus
);

    localparam int unsigned PtrW = ptr_width(NUM_CORES);

    arb_state_e            state_q, state_d;
    logic [NUM_CORES-1:0]  grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [PtrW-1:0]       ptr_q,   ptr_d;

    logic [NUM_CORES-1:0]  eligible;
    logic [NUM_CORES-1:0]  win_oh;
    logic [PtrW-1:0]       win_idx;
    logic                  win_any;

    assign eligible = bus.Req & bus.Core_Enable;

    rr_priority_picker #(
        .NUM_CORES (NUM_CORES),
        .PTR_WIDTH (PtrW)
    ) u_picker (
        .eligible_i   (eligible),
        .ptr_i        (ptr_q),
        .winner_oh_o  (win_oh),
        .winner_idx_o (win_idx),
        .any_o        (win_any)
    );

    // Next-state: grant the winner and latch its PC, or drop to idle holding address/pointer.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        if (win_any) begin
            state_d = SERVE;
            grant_d = win_oh;
            for (int i = 0; i < int'(NUM_CORES); i++) begin
                if (win_oh[i]) addr_d = bus.PC[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
            ptr_d = (win_idx == PtrW'(NUM_CORES - 1)) ? '0 : win_idx + 1'b1;
        end else begin
            state_d = IDLE;
            grant_d = '0;
        end
    end

    // Arbitration state register with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            addr_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.Mem_Address = addr_q;
    assign bus.Resp_Valid  = grant_q;
    assign bus.Instruction = bus.Mem_Instruction;
    assign bus.Busy        = (state_q == SERVE);

`ifdef IMEM_ARB_PERF_EN
    logic [NUM_CORES-1:0][31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles each core is eligible but loses, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (eligible[i] && !win_oh[i] && (stall_cnt_q[i] != 32'hFFFF_FFFF)) begin
                stall_cnt_d[i] = stall_cnt_q[i] + 32'd1;
            end
        end
    end

    // Stall counter register.
    always_ff @(posedge Clk) begin
        if (Rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign bus.Perf_Stall_Count = stall_cnt_q;
`endif

endmodule
